// File: rtl/fabric_reset_pkg.sv
// fabric_reset_pkg
// Shared types and constants for the fabric reset controller:
//   state_e        - sequencer state encoding (also exported on state_dbg)
//   CAUSE_LOCK/DBG - bit positions inside reset_cause
//   LOSS_COUNT_MAX - saturation ceiling of the lock-loss counter
//   sat_inc()      - saturating increment for the 8-bit loss counter
package fabric_reset_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_FAB_REL   = 3'd2,
    ST_RUN       = 3'd3,
    ST_DBG_HOLD  = 3'd4
  } state_e;

  localparam int CAUSE_LOCK = 0;
  localparam int CAUSE_DBG  = 1;

  localparam logic [7:0] LOSS_COUNT_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == LOSS_COUNT_MAX) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/fabric_reset_ctrl_sync_bit.sv
// sync_bit
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
// The chain clears to 0 asynchronously so a held reset always reads "not ready".
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear of every stage
//   d     - asynchronous input level
//   q     - synchronized level, STAGES clk edges behind d
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/fabric_reset_ctrl.sv
// fabric_reset_ctrl
// Staged reset sequencer sitting behind the fabric PLL. Waits for a filtered
// PLL lock (qualified by device init-done), releases the fabric reset, then
// the processor core reset a fixed delay later. Lock loss after release pulls
// both resets straight back; the debug module can request a core-only reset.
// Ports:
//   clk            - PLL fabric clock
//   ext_rst_n      - board reset, asynchronous active-low
//   pll_lock       - PLL lock flag, asynchronous
//   init_done      - device init complete, asynchronous
//   debug_rst_req  - single-cycle core reset request (clk domain)
//   cause_clr      - single-cycle clear of reset_cause (clk domain)
//   fabric_reset_n - fabric reset, active-low, registered
//   core_reset_n   - processor reset, active-low, registered
//   lock_lost      - one-cycle pulse when lock drops after release
//   reset_cause    - sticky cause bits: [0] lock loss, [1] debug reset
//   loss_count     - saturating count of lock-loss events
//   state_dbg      - current sequencer state
module fabric_reset_ctrl
  import fabric_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_FILTER_CYCLES = 1024,
  parameter int CORE_DELAY_CYCLES  = 16,
  parameter int DBG_HOLD_CYCLES    = 8,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       ext_rst_n,
  input  logic       pll_lock,
  input  logic       init_done,
  input  logic       debug_rst_req,
  input  logic       cause_clr,
  output logic       fabric_reset_n,
  output logic       core_reset_n,
  output logic       lock_lost,
  output logic [1:0] reset_cause,
  output logic [7:0] loss_count,
  output logic [2:0] state_dbg
);

  localparam logic [CNT_W-1:0] LOCK_TGT = CNT_W'(LOCK_FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CORE_TGT = CNT_W'(CORE_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] DBG_TGT  = CNT_W'(DBG_HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic lock_s;
  logic init_s;
  logic ok;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk   (clk),
    .rst_n (ext_rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_init (
    .clk   (clk),
    .rst_n (ext_rst_n),
    .d     (init_done),
    .q     (init_s)
  );

  assign ok = lock_s & init_s;

  state_e           state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             fabric_reg, fabric_next;
  logic             core_reg,   core_next;
  logic             lost_reg,   lost_next;
  logic [1:0]       cause_reg,  cause_next;
  logic [7:0]       loss_reg,   loss_next;
  logic             lock_loss;

  // Loss of ok only counts once the fabric has been released; dropping out
  // of the filter is just an unfinished lock attempt.
  assign lock_loss = !ok && (state_reg == ST_FAB_REL || state_reg == ST_RUN ||
                             state_reg == ST_DBG_HOLD);

  always_ff @(posedge clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state_reg  <= ST_WAIT_LOCK;
      cnt_reg    <= '0;
      fabric_reg <= 1'b0;
      core_reg   <= 1'b0;
      lost_reg   <= 1'b0;
      cause_reg  <= 2'b00;
      loss_reg   <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      fabric_reg <= fabric_next;
      core_reg   <= core_next;
      lost_reg   <= lost_next;
      cause_reg  <= cause_next;
      loss_reg   <= loss_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    fabric_next = fabric_reg;
    core_next   = core_reg;
    lost_next   = 1'b0;
    loss_next   = loss_reg;
    // Clear first so a cause set later in this block wins over cause_clr.
    cause_next  = cause_clr ? 2'b00 : cause_reg;

    if (lock_loss) begin
      state_next             = ST_WAIT_LOCK;
      cnt_next               = '0;
      fabric_next            = 1'b0;
      core_next              = 1'b0;
      lost_next              = 1'b1;
      cause_next[CAUSE_LOCK] = 1'b1;
      loss_next              = sat_inc(loss_reg);
    end else begin
      case (state_reg)
        ST_WAIT_LOCK: begin
          fabric_next = 1'b0;
          core_next   = 1'b0;
          cnt_next    = '0;
          if (ok) begin
            state_next = ST_FILTER;
            cnt_next   = CNT_ONE;
          end
        end
        ST_FILTER: begin
          fabric_next = 1'b0;
          core_next   = 1'b0;
          if (!ok) begin
            // Any glitch throws away the accumulated lock time.
            state_next = ST_WAIT_LOCK;
            cnt_next   = '0;
          end else if (cnt_reg == LOCK_TGT) begin
            state_next  = ST_FAB_REL;
            fabric_next = 1'b1;
            cnt_next    = CNT_ONE;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        ST_FAB_REL: begin
          fabric_next = 1'b1;
          core_next   = 1'b0;
          if (cnt_reg == CORE_TGT) begin
            state_next = ST_RUN;
            core_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        ST_RUN: begin
          fabric_next = 1'b1;
          core_next   = 1'b1;
          if (debug_rst_req) begin
            state_next            = ST_DBG_HOLD;
            core_next             = 1'b0;
            cnt_next              = CNT_ONE;
            cause_next[CAUSE_DBG] = 1'b1;
          end
        end
        ST_DBG_HOLD: begin
          // Requests arriving here are dropped; the hold is not restarted.
          fabric_next = 1'b1;
          core_next   = 1'b0;
          if (cnt_reg == DBG_TGT) begin
            state_next = ST_RUN;
            core_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_next  = ST_WAIT_LOCK;
          cnt_next    = '0;
          fabric_next = 1'b0;
          core_next   = 1'b0;
        end
      endcase
    end
  end

  assign fabric_reset_n = fabric_reg;
  assign core_reset_n   = core_reg;
  assign lock_lost      = lost_reg;
  assign reset_cause    = cause_reg;
  assign loss_count     = loss_reg;
  assign state_dbg      = state_reg;

endmodule
